// File: rtl/param_est_mul_share_arb.sv
// Round-robin shared 16x7 multiplier for the ParamEst_NN datapath.
// Two pipeline stages (operands -> product); results carry the requester ID.
module param_est_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DIN0_W  = 16,
    parameter int DIN1_W  = 7,
    parameter int DOUT_W  = 22,
    parameter int CNT_W   = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DIN0_W-1:0] req_din0,
    input  logic [NUM_REQ*DIN1_W-1:0] req_din1,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DOUT_W-1:0]         rsp_dout,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          op_count
);

    logic [DIN0_W-1:0] din0_arr [NUM_REQ];
    logic [DIN1_W-1:0] din1_arr [NUM_REQ];

    logic              s1_vld_reg;
    logic [DIN0_W-1:0] s1_a_reg;
    logic [DIN1_W-1:0] s1_b_reg;
    logic [ID_W-1:0]   s1_id_reg;
    logic              s2_vld_reg;
    logic [DOUT_W-1:0] s2_p_reg;
    logic [ID_W-1:0]   s2_id_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [CNT_W-1:0]  op_count_reg;

    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     cand;
    logic [ID_W-1:0]   rr_ptr_next;
    logic              stall;
    logic              adv1;
    logic              accept;
    logic [DOUT_W-1:0] prod;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign din0_arr[gi]  = req_din0[gi*DIN0_W +: DIN0_W];
            assign din1_arr[gi]  = req_din1[gi*DIN1_W +: DIN1_W];
            assign req_ready[gi] = adv1 & grant_vld & (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Search from rr_ptr upward; the extra bit lets the index wrap at NUM_REQ
    // even when NUM_REQ is not a power of two.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    assign stall       = s2_vld_reg & ~rsp_ready;
    assign adv1        = ~s1_vld_reg | ~stall;
    assign accept      = adv1 & grant_vld;
    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Multiplying at DOUT_W width keeps exactly the low product bits.
    assign prod = DOUT_W'(s1_a_reg) * DOUT_W'(s1_b_reg);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s1_vld_reg   <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_id_reg    <= '0;
            s2_vld_reg   <= 1'b0;
            s2_p_reg     <= '0;
            s2_id_reg    <= '0;
            rr_ptr_reg   <= '0;
            op_count_reg <= '0;
        end else begin
            if (adv1) begin
                s1_vld_reg <= accept;
                if (accept) begin
                    s1_a_reg   <= din0_arr[grant_idx];
                    s1_b_reg   <= din1_arr[grant_idx];
                    s1_id_reg  <= grant_idx;
                    rr_ptr_reg <= rr_ptr_next;
                    if (op_count_reg != '1)
                        op_count_reg <= op_count_reg + CNT_W'(1);
                end
            end
            if (!stall) begin
                s2_vld_reg <= s1_vld_reg;
                s2_id_reg  <= s1_id_reg;
                s2_p_reg   <= prod;
            end
        end
    end

    assign rsp_valid = s2_vld_reg;
    assign rsp_dout  = s2_p_reg;
    assign rsp_id    = s2_id_reg;
    assign busy      = s1_vld_reg | s2_vld_reg;
    assign op_count  = op_count_reg;

endmodule
